// File: rtl/conv2d_engine.sv
// conv2d_engine: serial-loaded kernel/matrix 2-D valid convolution, one MAC per cycle, streamed results
module conv2d_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int MATRIX_DIM = 32,
  parameter int CONV_DIM = 3,
  parameter int STRIDE = 1,
  localparam int OUT_DIM = (MATRIX_DIM - CONV_DIM) / STRIDE + 1,
  localparam int ACC_WIDTH = 2 * DATA_WIDTH + $clog2(CONV_DIM * CONV_DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_kernel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  start,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  done
);
  localparam int KN = CONV_DIM * CONV_DIM;
  localparam int MN = MATRIX_DIM * MATRIX_DIM;
  localparam int KPW = KN > 1 ? $clog2(KN) : 1;
  localparam int MPW = MN > 1 ? $clog2(MN) : 1;
  localparam int CW = CONV_DIM > 1 ? $clog2(CONV_DIM) : 1;
  localparam int OW = OUT_DIM > 1 ? $clog2(OUT_DIM) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
  state_t state, state_n;
  logic signed [DATA_WIDTH-1:0] kmem [KN];
  logic signed [DATA_WIDTH-1:0] mmem [MN];
  logic [KPW-1:0] kptr;
  logic [MPW-1:0] mptr;
  logic [CW-1:0] kx, ky;
  logic [OW-1:0] bx, by;
  logic signed [ACC_WIDTH-1:0] acc;
  logic relu;
  logic [31:0] k_lin, m_lin;
  logic signed [PW-1:0] prod;
  logic last_kx, last_ky, last_bx, last_out, fire, idle_start;
  assign last_kx = kx == CW'(CONV_DIM - 1);
  assign last_ky = ky == CW'(CONV_DIM - 1);
  assign last_bx = bx == OW'(OUT_DIM - 1);
  assign last_out = last_bx && by == OW'(OUT_DIM - 1);
  assign fire = state == EMIT && out_ready;
  assign idle_start = state == IDLE && start;
  assign busy = state != IDLE;
  assign out_valid = state == EMIT;
  assign out_last = out_valid && last_out;
  assign out_data = out_valid && !(relu && acc[ACC_WIDTH-1]) ? acc : '0;
  always_comb begin
    k_lin = 32'(ky) * CONV_DIM + 32'(kx);
    m_lin = (32'(by) * STRIDE + 32'(ky)) * MATRIX_DIM + 32'(bx) * STRIDE + 32'(kx);
    prod = PW'(kmem[k_lin[KPW-1:0]]) * PW'(mmem[m_lin[MPW-1:0]]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? ACCUM : IDLE) :
              state == ACCUM ? (last_kx && last_ky ? EMIT : ACCUM) :
              out_ready ? (last_out ? IDLE : ACCUM) : EMIT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      kx <= '0;
      ky <= '0;
      bx <= '0;
      by <= '0;
      relu <= 1'b0;
      done <= 1'b0;
      kptr <= '0;
      mptr <= '0;
      for (int i = 0; i < KN; i++) kmem[i] <= '0;
      for (int i = 0; i < MN; i++) mmem[i] <= '0;
    end else begin
      done <= fire && last_out;
      if (idle_start) begin
        acc <= '0;
        kx <= '0;
        ky <= '0;
        bx <= '0;
        by <= '0;
        relu <= relu_en;
        kptr <= '0;
        mptr <= '0;
      end else if (state == IDLE && wr_en && wr_kernel) begin
        kmem[kptr] <= wr_data;
        kptr <= kptr == KPW'(KN - 1) ? '0 : kptr + 1'b1;
      end else if (state == IDLE && wr_en) begin
        mmem[mptr] <= wr_data;
        mptr <= mptr == MPW'(MN - 1) ? '0 : mptr + 1'b1;
      end
      if (state == ACCUM) begin
        acc <= acc + ACC_WIDTH'(prod);
        kx <= last_kx ? '0 : kx + 1'b1;
        if (last_kx) ky <= last_ky ? '0 : ky + 1'b1;
      end
      if (fire && !last_out) begin
        acc <= '0;
        bx <= last_bx ? '0 : bx + 1'b1;
        if (last_bx) by <= by + 1'b1;
      end
    end
endmodule

// File: tb/tb_conv2d_engine.sv
// tb_conv2d_engine: scoreboard bench for conv2d_engine at N=4/S=1 and N=5/S=2
module tb_conv2d_engine;
  logic clk = 0, rst = 1;
  logic wr_en_a = 0, wr_en_b = 0, wr_kernel = 0, start_a = 0, start_b = 0, relu_en = 0, out_ready = 1;
  logic [7:0] wr_data = 0;
  logic busy_a, out_valid_a, out_last_a, done_a;
  logic busy_b, out_valid_b, out_last_b, done_b;
  logic [19:0] out_data_a, out_data_b;
  int chk_cnt = 0, pass_cnt = 0, cyc = 0, done_cnt_a = 0, done_cnt_b = 0, lat = 0, dc = 0;
  typedef struct {longint d; bit l;} exp_t;
  exp_t exp_a[$], exp_b[$], e_a, e_b;
  int hs_q[$];
  bit last_hs_a = 0, last_hs_b = 0;
  always #5 clk = ~clk;
  conv2d_engine #(.DATA_WIDTH(8), .MATRIX_DIM(4), .CONV_DIM(3), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_kernel(wr_kernel), .wr_data(wr_data),
    .start(start_a), .relu_en(relu_en), .busy(busy_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .out_last(out_last_a), .done(done_a));
  conv2d_engine #(.DATA_WIDTH(8), .MATRIX_DIM(5), .CONV_DIM(3), .STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_kernel(wr_kernel), .wr_data(wr_data),
    .start(start_b), .relu_en(relu_en), .busy(busy_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_data(out_data_b), .out_last(out_last_b), .done(done_b));
  task automatic chk(input string tag, input longint got, input longint exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input bit to_b, input bit k, input int v);
    wr_en_a = !to_b;
    wr_en_b = to_b;
    wr_kernel = k;
    wr_data = 8'(v);
    tick();
    wr_en_a = 0;
    wr_en_b = 0;
  endtask
  task automatic pa(input longint v, input bit l);
    exp_a.push_back('{v, l});
  endtask
  task automatic pa4(input longint v);
    for (int i = 0; i < 4; i++) pa(v, i == 3);
  endtask
  task automatic go_a(input bit relu, output int n);
    relu_en = relu;
    start_a = 1;
    tick();
    start_a = 0;
    n = 0;
    while (!out_valid_a && n < 100) begin
      tick();
      n++;
    end
  endtask
  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 1000) begin
      tick();
      n++;
    end
    chk("a_done_seen", done_a, 1);
  endtask
  task automatic load_center();
    for (int i = 0; i < 9; i++) wr(0, 1, int'(i == 4));
    for (int i = 0; i < 16; i++) wr(0, 0, i);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (last_hs_a) chk("a_done_pulse", done_a, 1);
    if (done_a) done_cnt_a++;
    last_hs_a = out_valid_a && out_ready && out_last_a;
    if (out_valid_a && out_ready) begin
      hs_q.push_back(cyc);
      if (exp_a.size() == 0) chk("a_unexpected_out", exp_a.size(), 1);
      else begin
        e_a = exp_a.pop_front();
        chk("a_data", $signed(out_data_a), e_a.d);
        chk("a_last", out_last_a, e_a.l);
      end
    end
    if (last_hs_b) chk("b_done_pulse", done_b, 1);
    if (done_b) done_cnt_b++;
    last_hs_b = out_valid_b && out_ready && out_last_b;
    if (out_valid_b && out_ready) begin
      if (exp_b.size() == 0) chk("b_unexpected_out", exp_b.size(), 1);
      else begin
        e_b = exp_b.pop_front();
        chk("b_data", $signed(out_data_b), e_b.d);
        chk("b_last", out_last_b, e_b.l);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", out_valid_a, 0);
    chk("rst_last", out_last_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_data", out_data_a, 0);
    rst = 0;
    tick();
    load_center();
    pa(5, 0); pa(6, 0); pa(9, 0); pa(10, 1);
    go_a(0, lat);
    wait_done_a();
    chk("t1_drained", exp_a.size(), 0);
    for (int i = 0; i < 9; i++) wr(0, 1, 1);
    for (int i = 0; i < 16; i++) wr(0, 0, 2);
    pa4(18);
    hs_q.delete();
    go_a(0, lat);
    chk("t2_first_valid_lat", lat, 9);
    wait_done_a();
    chk("t2_hs_count", hs_q.size(), 4);
    for (int i = 1; i < hs_q.size(); i++) chk("t2_interval", hs_q[i] - hs_q[i-1], 10);
    for (int i = 0; i < 9; i++) wr(0, 1, -1);
    for (int i = 0; i < 16; i++) wr(0, 0, 1);
    pa4(-9);
    go_a(0, lat);
    wait_done_a();
    pa4(0);
    go_a(1, lat);
    wait_done_a();
    for (int i = 0; i < 9; i++) wr(0, 1, -128);
    for (int i = 0; i < 16; i++) wr(0, 0, -128);
    pa4(147456);
    go_a(0, lat);
    wait_done_a();
    load_center();
    pa(5, 0); pa(6, 0); pa(9, 0); pa(10, 1);
    out_ready = 0;
    go_a(0, lat);
    chk("bp_first_valid_lat", lat, 9);
    for (int i = 0; i < 10; i++) begin
      wr_en_a = (i % 2 == 1);
      wr_kernel = 1;
      wr_data = 8'h55;
      start_a = (i == 3);
      tick();
      chk("bp_valid", out_valid_a, 1);
      chk("bp_data", $signed(out_data_a), 5);
      chk("bp_last", out_last_a, 0);
    end
    wr_en_a = 0;
    start_a = 0;
    out_ready = 1;
    wr_kernel = 0;
    wr_data = 8'hAA;
    wr_en_a = 1;
    repeat (5) tick();
    wr_en_a = 0;
    wait_done_a();
    pa(5, 0); pa(6, 0); pa(9, 0); pa(10, 1);
    go_a(0, lat);
    wait_done_a();
    for (int i = 0; i < 9; i++) wr(1, 1, 1);
    for (int i = 0; i < 25; i++) wr(1, 0, i);
    exp_b.push_back('{54, 0});
    exp_b.push_back('{72, 0});
    exp_b.push_back('{144, 0});
    exp_b.push_back('{162, 1});
    relu_en = 0;
    start_b = 1;
    tick();
    start_b = 0;
    for (int n = 0; n < 200 && !done_b; n++) tick();
    chk("b_done_seen", done_b, 1);
    repeat (2) tick();
    dc = done_cnt_a;
    start_a = 1;
    tick();
    start_a = 0;
    repeat (2) tick();
    chk("pre_rst_busy", busy_a, 1);
    rst = 1;
    #2;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_valid", out_valid_a, 0);
    chk("mid_rst_data", out_data_a, 0);
    chk("mid_rst_done", done_a, 0);
    tick();
    rst = 0;
    repeat (5) tick();
    chk("mid_rst_no_done", done_cnt_a, dc);
    pa4(0);
    go_a(0, lat);
    wait_done_a();
    for (int i = 0; i < 9; i++) wr(0, 1, 0);
    wr(0, 1, 7);
    for (int i = 0; i < 16; i++) wr(0, 0, i);
    pa(0, 0); pa(7, 0); pa(28, 0); pa(35, 1);
    go_a(0, lat);
    wait_done_a();
    repeat (3) tick();
    chk("a_queue_empty", exp_a.size(), 0);
    chk("b_queue_empty", exp_b.size(), 0);
    chk("a_done_count", done_cnt_a, 9);
    chk("b_done_count", done_cnt_b, 1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/conv2d_engine.md
# conv2d_engine

Parametrised successor to the single-channel TPU convolution datapath. It holds a CONV_DIM×CONV_DIM kernel and a MATRIX_DIM×MATRIX_DIM input matrix, both loaded serially. On `start` it computes every valid (unpadded) output of the 2-D convolution at a programmable STRIDE, one output at a time, using one signed multiply-accumulate per cycle. Results stream out over a valid/ready handshake with back-pressure, an optional ReLU, and last/done markers for the downstream writer.

## Interface
- DATA_WIDTH, 8: signed two's-complement width of kernel and matrix elements.
- MATRIX_DIM, 32: input matrix side length; must be ≥ CONV_DIM.
- CONV_DIM, 3: kernel side length; must be ≥ 1.
- STRIDE, 1: output step in x and y; must be ≥ 1.
- Derived OUT_DIM = (MATRIX_DIM−CONV_DIM)/STRIDE + 1 (floor division).
- Derived ACC_WIDTH = 2·DATA_WIDTH + $clog2(CONV_DIM·CONV_DIM).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write one element.
- wr_kernel  in  1  1 = write targets kernel, 0 = write targets matrix.
- wr_data  in  DATA_WIDTH  element written.
- start  in  1  begin convolution; sampled only in IDLE.
- relu_en  in  1  clamp negative results to 0; sampled with `start`.
- busy  out  1  high in ACCUM/EMIT.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_WIDTH  signed result.
- out_last  out  1  qualifies the final result (with out_valid).
- done  out  1  one-cycle pulse after the final result is accepted.

## Operation
- Storage: kernel array (CONV_DIM²) and matrix array (MATRIX_DIM²) of DATA_WIDTH registers, combinational read, all cleared to 0 on rst.
- Loading (IDLE only): each wr_en cycle writes wr_data at the selected array's write pointer, then increments that pointer. Order is raster: x fastest, then y.
  - Kernel and matrix have independent pointers; each wraps to 0 after its last entry.
  - Both pointers clear on rst and when start is accepted.
  - wr_en is ignored while busy.
- FSM IDLE → ACCUM → EMIT:
  - IDLE: start=1 → ACCUM. Clears acc, kernel index (kx,ky)=(0,0), base (bx,by)=(0,0), and latches relu_en.
  - ACCUM: each cycle acc += sext(K[ky][kx]) · sext(M[by·STRIDE+ky][bx·STRIDE+kx]). Kernel index advances raster-order. After the (CONV_DIM−1, CONV_DIM−1) term → EMIT.
  - EMIT: out_valid=1, out_data = (relu && acc<0) ? 0 : acc, held stable until out_ready.
    - On handshake, if not the last output: advance base raster-order, clear acc and kernel index → ACCUM.
    - If last (bx=by=OUT_DIM−1): → IDLE and pulse done.
- Arithmetic: full-precision signed, no saturation. ACC_WIDTH cannot overflow for CONV_DIM² products.
- start while busy is ignored. start and wr_en together in IDLE: start wins and the write is dropped.
- Matrix columns/rows beyond (OUT_DIM−1)·STRIDE+CONV_DIM−1 are never read.

## Timing
- Reset values: busy=0, out_valid=0, out_last=0, done=0, out_data=0, FSM=IDLE.
- rst mid-operation: immediate return to IDLE, arrays cleared, no done pulse.
- start accepted at edge T → busy=1 from T. First MAC is in cycle T..T+1; out_valid rises at edge T+CONV_DIM².
- With out_ready held high: one result per CONV_DIM²+1 cycles. Total run = OUT_DIM²·(CONV_DIM²+1) cycles.
- out_ready low: FSM stalls in EMIT indefinitely; out_data and out_last stay constant.
- Final handshake at edge E → done=1 and busy=0 for cycle E..E+1. out_valid=0 from E. start is accepted again from edge E+1.
- out_valid never depends combinationally on out_ready.

## Test plan
- DATA_WIDTH=8, N=4, K=3, S=1. Kernel all 0 except center=1; matrix = 0..15 raster → outputs 5, 6, 9, 10; out_last only on 10; done one cycle after its handshake.
- N=4, K=3. Kernel all 1, matrix all 2 → four outputs of 18. First out_valid exactly 9 cycles after start; results 10 cycles apart with out_ready=1.
- N=5, K=3, S=2. Kernel all 1, matrix = 0..24 → OUT_DIM=2; outputs 54, 72, 144, 162.
- Kernel all −1 (0xFF), matrix all 1: relu_en=0 → −9 (sign-extended); relu_en=1 → 0. Also kernel all −128, matrix all −128 → 147456 with no overflow.
- Back-pressure: out_ready low for 10 cycles in EMIT → out_data/out_valid stable, no advance; wr_en and start pulses during busy have no effect on results or arrays.
- Assert rst mid-ACCUM → all outputs 0 next cycle, arrays read back 0 (new run yields all-zero results), no done pulse; pointer wrap: 10 kernel writes with K=3 leave entry 0 = 10th value.
